// File: rtl/reply_transmitter_pkg.sv
// Shared definitions for the reply-channel frame. Used by the receiver-side
// transmitter and by the transmitter-side reply decoder.
package reply_transmitter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        ACTION = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    localparam int FRAME_BITS   = 14;
    localparam int ACTION_BITS  = 3;
    localparam int DATA_BITS    = 8;
    localparam int PAYLOAD_BITS = ACTION_BITS + DATA_BITS;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [PAYLOAD_BITS-1:0] payload);
        return ^payload;
    endfunction

endpackage

// File: rtl/reply_transmitter_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last count so the owner can advance one serial bit.
module baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign tick = en && (count == LAST);

    // NOTE: registers are updated with <= so every flop samples values from
    // before the edge; blocking assignments here would create ordering races.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/reply_transmitter.sv
// Return-channel serializer: snapshots an action code and eight cell bits on
// start and sends them as one framed, even-parity serial word on reply_line.
module reply_transmitter
    import reply_transmitter_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic action0,
    input  logic action1,
    input  logic action2,
    input  logic c0,
    input  logic c1,
    input  logic c2,
    input  logic c3,
    input  logic c4,
    input  logic c5,
    input  logic c6,
    input  logic c7,
    output logic reply_line,
    output logic busy,
    output logic done
);

    state_t                  state;
    logic [2:0]              bit_idx;
    logic [PAYLOAD_BITS-1:0] snap;
    logic [PAYLOAD_BITS-1:0] payload_in;
    logic [3:0]              next_pos;
    logic                    tick;
    logic                    accept;

    // Payload is laid out in transmit order: action0 at bit 0, c7 at bit 10.
    assign payload_in = {c7, c6, c5, c4, c3, c2, c1, c0, action2, action1, action0};
    assign accept     = start && !busy;

    // Snapshot position of the bit that follows the current one; the last
    // action bit naturally points at c0.
    always_comb begin
        next_pos = {1'b0, bit_idx} + 4'd1;
        if (state == DATA) begin
            next_pos = 4'(ACTION_BITS) + {1'b0, bit_idx} + 4'd1;
        end
    end

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(accept),
        .en   (busy),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            bit_idx    <= '0;
            snap       <= '0;
            reply_line <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        snap       <= payload_in;
                        state      <= START;
                        bit_idx    <= '0;
                        busy       <= 1'b1;
                        reply_line <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state      <= ACTION;
                        bit_idx    <= '0;
                        reply_line <= snap[0];
                    end
                end
                ACTION: begin
                    if (tick) begin
                        reply_line <= snap[next_pos];
                        if (bit_idx == 3'(ACTION_BITS - 1)) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            state      <= PARITY;
                            bit_idx    <= '0;
                            reply_line <= even_parity(snap);
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            reply_line <= snap[next_pos];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state      <= STOP;
                        reply_line <= 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reply_transmitter.sv
// Self-checking bench for reply_transmitter at CLKS_PER_BIT=4 and =1, checked
// cycle by cycle against a bit-list model of the frame.
module tb_reply_transmitter;

    import reply_transmitter_pkg::*;

    localparam int MAXC = 256;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       start4 = 1'b0;
    logic       start1 = 1'b0;
    logic [2:0] act    = '0;
    logic [7:0] cells  = '0;
    logic       line4, busy4, done4;
    logic       line1, busy1, done1;

    int total = 0;
    int bad   = 0;

    logic obs_line [MAXC];
    logic obs_busy [MAXC];
    logic obs_done [MAXC];
    logic exp_line [MAXC];
    logic exp_busy [MAXC];
    logic exp_done [MAXC];

    always #5 clk = ~clk;

    reply_transmitter #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .action0(act[0]), .action1(act[1]), .action2(act[2]),
        .c0(cells[0]), .c1(cells[1]), .c2(cells[2]), .c3(cells[3]),
        .c4(cells[4]), .c5(cells[5]), .c6(cells[6]), .c7(cells[7]),
        .reply_line(line4), .busy(busy4), .done(done4)
    );

    reply_transmitter #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .action0(act[0]), .action1(act[1]), .action2(act[2]),
        .c0(cells[0]), .c1(cells[1]), .c2(cells[2]), .c3(cells[3]),
        .c4(cells[4]), .c5(cells[5]), .c6(cells[6]), .c7(cells[7]),
        .reply_line(line1), .busy(busy1), .done(done1)
    );

    // Frame as a list of bits in time order, built from the frame rules.
    function automatic logic [FRAME_BITS-1:0] ref_frame(input logic [2:0] a, input logic [7:0] c);
        logic [FRAME_BITS-1:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            f[1+i] = a[i];
            ones += int'(a[i]);
        end
        for (int i = 0; i < 8; i++) begin
            f[4+i] = c[i];
            ones += int'(c[i]);
        end
        f[12] = (ones % 2) == 1;
        f[13] = 1'b1;
        return f;
    endfunction

    function automatic void model_idle(input int from, input int to);
        for (int k = from; k < to; k++) begin
            exp_line[k] = 1'b1;
            exp_busy[k] = 1'b0;
            exp_done[k] = 1'b0;
        end
    endfunction

    // Expected outputs from the cycle after acceptance: every bit held cpb
    // cycles, then one done cycle with the line high.
    function automatic void model_frame(input int off, input int cpb, input logic [2:0] a, input logic [7:0] c);
        logic [FRAME_BITS-1:0] f;
        f = ref_frame(a, c);
        for (int k = 0; k < FRAME_BITS * cpb; k++) begin
            exp_line[off+k] = f[k/cpb];
            exp_busy[off+k] = 1'b1;
            exp_done[off+k] = 1'b0;
        end
        exp_line[off+FRAME_BITS*cpb] = 1'b1;
        exp_busy[off+FRAME_BITS*cpb] = 1'b0;
        exp_done[off+FRAME_BITS*cpb] = 1'b1;
    endfunction

    task automatic launch(input bit sel1, input logic [2:0] a, input logic [7:0] c);
        act   = a;
        cells = c;
        if (sel1) start1 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    // Records n cycles of outputs; optionally pulses start with new inputs at poke_at.
    task automatic capture(input bit sel1, input int n, input int poke_at,
                           input logic [2:0] pa, input logic [7:0] pc);
        for (int i = 0; i < n; i++) begin
            obs_line[i] = sel1 ? line1 : line4;
            obs_busy[i] = sel1 ? busy1 : busy4;
            obs_done[i] = sel1 ? done1 : done4;
            if (i == poke_at) begin
                act   = pa;
                cells = pc;
                if (sel1) start1 = 1'b1; else start4 = 1'b1;
            end else if (i == poke_at + 1) begin
                start1 = 1'b0;
                start4 = 1'b0;
            end
            @(negedge clk);
        end
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({line4, busy4, done4, line1, busy1, done1} !== 6'b100_100) begin
            bad++;
            $display("FAIL reset_held got=%b%b%b/%b%b%b want=100/100", line4, busy4, done4, line1, busy1, done1);
        end
        rst = 1'b1;
        capture(1'b0, 20, -1, '0, '0);
        model_idle(0, 20);
        for (int k = 0; k < 20; k++) begin
            total++;
            if ({obs_line[k], obs_busy[k], obs_done[k]} !== {exp_line[k], exp_busy[k], exp_done[k]}) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%b%b%b want=%b%b%b", k,
                         obs_line[k], obs_busy[k], obs_done[k], exp_line[k], exp_busy[k], exp_done[k]);
            end
        end
    endtask

    task automatic test_basic();
        int busy_len;
        int done_cnt;
        launch(1'b0, 3'b101, 8'b1000_1101);
        capture(1'b0, 60, -1, '0, '0);
        model_frame(0, 4, 3'b101, 8'b1000_1101);
        model_idle(57, 60);
        busy_len = 0;
        done_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            busy_len += int'(obs_busy[k] === 1'b1);
            done_cnt += int'(obs_done[k] === 1'b1);
            total++;
            if ({obs_line[k], obs_busy[k], obs_done[k]} !== {exp_line[k], exp_busy[k], exp_done[k]}) begin
                bad++;
                $display("FAIL basic cyc=%0d got=%b%b%b want=%b%b%b", k,
                         obs_line[k], obs_busy[k], obs_done[k], exp_line[k], exp_busy[k], exp_done[k]);
            end
        end
        total++;
        if (busy_len != 56 || done_cnt != 1) begin
            bad++;
            $display("FAIL basic_len busy=%0d done=%0d want 56/1", busy_len, done_cnt);
        end
        total++;
        if (obs_line[48] !== 1'b0) begin
            bad++;
            $display("FAIL basic_parity got=%b want=0", obs_line[48]);
        end
    endtask

    task automatic test_snapshot_ignore();
        logic [2:0] a;
        logic [7:0] c;
        a = 3'($urandom);
        c = 8'($urandom);
        launch(1'b0, a, c);
        capture(1'b0, 70, 10, ~a, ~c);
        model_frame(0, 4, a, c);
        model_idle(57, 70);
        for (int k = 0; k < 70; k++) begin
            total++;
            if ({obs_line[k], obs_busy[k], obs_done[k]} !== {exp_line[k], exp_busy[k], exp_done[k]}) begin
                bad++;
                $display("FAIL snapshot cyc=%0d got=%b%b%b want=%b%b%b", k,
                         obs_line[k], obs_busy[k], obs_done[k], exp_line[k], exp_busy[k], exp_done[k]);
            end
        end
    endtask

    task automatic test_back_to_back(input bit sel1, input int cpb);
        logic [2:0] a;
        logic [7:0] c;
        int n;
        a = 3'($urandom);
        c = 8'($urandom);
        n = 2 * (FRAME_BITS * cpb + 1) + 3;
        launch(sel1, a, c);
        capture(sel1, n, FRAME_BITS * cpb, 3'b000, 8'h00);
        model_frame(0, cpb, a, c);
        model_frame(FRAME_BITS * cpb + 1, cpb, 3'b000, 8'h00);
        model_idle(2 * (FRAME_BITS * cpb + 1), n);
        for (int k = 0; k < n; k++) begin
            total++;
            if ({obs_line[k], obs_busy[k], obs_done[k]} !== {exp_line[k], exp_busy[k], exp_done[k]}) begin
                bad++;
                $display("FAIL back_to_back cpb=%0d cyc=%0d got=%b%b%b want=%b%b%b", cpb, k,
                         obs_line[k], obs_busy[k], obs_done[k], exp_line[k], exp_busy[k], exp_done[k]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [2:0] a;
        logic [7:0] c;
        a = 3'($urandom);
        c = 8'($urandom);
        launch(1'b0, a, c);
        repeat (8 * 4 + 1) @(negedge clk);
        total++;
        if (busy4 !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy got=%b want=1", busy4);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({line4, busy4, done4} !== 3'b100) begin
            bad++;
            $display("FAIL mid_reset got=%b%b%b want=100", line4, busy4, done4);
        end
        @(negedge clk);
        rst = 1'b1;
        capture(1'b0, 6, -1, '0, '0);
        model_idle(0, 6);
        for (int k = 0; k < 6; k++) begin
            total++;
            if ({obs_line[k], obs_busy[k], obs_done[k]} !== {exp_line[k], exp_busy[k], exp_done[k]}) begin
                bad++;
                $display("FAIL mid_after cyc=%0d got=%b%b%b want=100", k, obs_line[k], obs_busy[k], obs_done[k]);
            end
        end
        a = 3'($urandom);
        c = 8'($urandom);
        launch(1'b0, a, c);
        capture(1'b0, 59, -1, '0, '0);
        model_frame(0, 4, a, c);
        model_idle(57, 59);
        for (int k = 0; k < 59; k++) begin
            total++;
            if ({obs_line[k], obs_busy[k], obs_done[k]} !== {exp_line[k], exp_busy[k], exp_done[k]}) begin
                bad++;
                $display("FAIL mid_reframe cyc=%0d got=%b%b%b want=%b%b%b", k,
                         obs_line[k], obs_busy[k], obs_done[k], exp_line[k], exp_busy[k], exp_done[k]);
            end
        end
    endtask

    task automatic test_odd_parity_fast();
        launch(1'b1, 3'b001, 8'h00);
        capture(1'b1, 17, -1, '0, '0);
        model_frame(0, 1, 3'b001, 8'h00);
        model_idle(15, 17);
        for (int k = 0; k < 17; k++) begin
            total++;
            if ({obs_line[k], obs_busy[k], obs_done[k]} !== {exp_line[k], exp_busy[k], exp_done[k]}) begin
                bad++;
                $display("FAIL odd_parity cyc=%0d got=%b%b%b want=%b%b%b", k,
                         obs_line[k], obs_busy[k], obs_done[k], exp_line[k], exp_busy[k], exp_done[k]);
            end
        end
        total++;
        if (obs_line[12] !== 1'b1) begin
            bad++;
            $display("FAIL odd_parity_bit got=%b want=1", obs_line[12]);
        end
    endtask

    task automatic test_random_frames();
        for (int t = 0; t < 8; t++) begin
            bit         sel1;
            int         cpb;
            logic [2:0] a;
            logic [7:0] c;
            sel1 = t[0];
            cpb  = sel1 ? 1 : 4;
            a    = 3'($urandom);
            c    = 8'($urandom);
            launch(sel1, a, c);
            capture(sel1, FRAME_BITS * cpb + 2, -1, '0, '0);
            model_frame(0, cpb, a, c);
            model_idle(FRAME_BITS * cpb + 1, FRAME_BITS * cpb + 2);
            for (int k = 0; k < FRAME_BITS * cpb + 2; k++) begin
                total++;
                if ({obs_line[k], obs_busy[k], obs_done[k]} !== {exp_line[k], exp_busy[k], exp_done[k]}) begin
                    bad++;
                    $display("FAIL random t=%0d cpb=%0d cyc=%0d got=%b%b%b want=%b%b%b", t, cpb, k,
                             obs_line[k], obs_busy[k], obs_done[k], exp_line[k], exp_busy[k], exp_done[k]);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_snapshot_ignore();
        test_back_to_back(1'b0, 4);
        test_back_to_back(1'b1, 1);
        test_reset_mid_frame();
        test_odd_parity_fast();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
